// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_xfer_ctrl
//  Description : SPI master transfer sequencer. Arms and stops the SPI clock
//                generator, counts bits from its edge pulses, issues per-bit
//                shift/sample strobes and drives slave selects, transfer
//                status and a latched interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_ctrl #(
    parameter int LEN_W = 7,
    parameter int SS_NB = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             go,
    input  logic             abort,
    input  logic [LEN_W-1:0] char_len,
    input  logic             rx_negedge,
    input  logic             tx_negedge,
    input  logic             ass,
    input  logic [SS_NB-1:0] ss,
    input  logic             ie,
    input  logic             irq_clr,
    input  logic             pos_edge,
    input  logic             neg_edge,
    output logic             clkgen_go,
    output logic             clkgen_en,
    output logic             last_clk,
    output logic             tip,
    output logic             tx_shift,
    output logic             rx_sample,
    output logic [LEN_W:0]   bit_cnt,
    output logic             done,
    output logic             aborted,
    output logic             irq,
    output logic [SS_NB-1:0] ss_pad_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // char_len of zero selects the full 2**LEN_W bit transfer
    localparam logic [LEN_W:0] c_FULL = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0] c_ONE  = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] c_ZERO = {(LEN_W+1){1'b0}};

    logic [1:0]       r_state;
    logic [LEN_W:0]   r_bit_cnt;
    logic             r_tip;
    logic             r_clkgen_go;
    logic             r_clkgen_en;
    logic             r_aborted;
    logic             r_irq;
    logic [SS_NB-1:0] r_ss_pad;

    logic [1:0]       w_state_nxt;
    logic [LEN_W:0]   w_cnt_nxt;
    logic             w_tip_nxt;
    logic             w_go_nxt;
    logic             w_en_nxt;
    logic             w_aborted_nxt;
    logic             w_irq_nxt;
    logic             w_irq_hold;
    logic [SS_NB-1:0] w_ss_nxt;
    logic             w_tx_edge;
    logic             w_rx_edge;
    logic             w_cnt_one;

    assign w_tx_edge = tx_negedge ? neg_edge : pos_edge;
    assign w_rx_edge = rx_negedge ? neg_edge : pos_edge;
    assign w_cnt_one = (r_bit_cnt == c_ONE);

    assign tx_shift  = w_tx_edge & r_tip & (r_bit_cnt != c_ZERO);
    assign rx_sample = w_rx_edge & r_tip;
    assign last_clk  = r_tip & w_cnt_one;
    assign tip       = r_tip;
    assign bit_cnt   = r_bit_cnt;
    assign clkgen_go = r_clkgen_go;
    assign clkgen_en = r_clkgen_en;
    assign aborted   = r_aborted;
    assign irq       = r_irq;
    assign ss_pad_o  = r_ss_pad;
    // an abort landing in the DONE cycle suppresses the completion pulse
    assign done      = (r_state == S_DONE) & ~abort;

    // Next-state, counter and status computation
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_bit_cnt;
        w_tip_nxt     = r_tip;
        w_go_nxt      = 1'b0;
        w_en_nxt      = r_clkgen_en;
        w_aborted_nxt = 1'b0;
        w_irq_hold    = irq_clr ? 1'b0 : r_irq;
        w_irq_nxt     = w_irq_hold;

        case (r_state)
            S_IDLE: begin
                if (go && !abort) begin
                    w_state_nxt = S_ARM;
                    w_cnt_nxt   = (char_len == {LEN_W{1'b0}}) ? c_FULL : {1'b0, char_len};
                    w_tip_nxt   = 1'b1;
                    w_go_nxt    = 1'b1;
                end
            end
            S_ARM: begin
                w_state_nxt = S_RUN;
                w_en_nxt    = 1'b1;
            end
            S_RUN: begin
                if (rx_sample && r_bit_cnt != c_ZERO) begin
                    w_cnt_nxt = r_bit_cnt - c_ONE;
                    if (w_cnt_one) begin
                        w_state_nxt = S_DONE;
                        w_en_nxt    = 1'b0;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_tip_nxt   = 1'b0;
                // set has priority over a simultaneous clear
                if (ie) w_irq_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tip_nxt   = 1'b0;
                w_en_nxt    = 1'b0;
            end
        endcase

        // abort overrides everything once a transfer has been accepted
        if (abort && r_state != S_IDLE) begin
            w_state_nxt   = S_IDLE;
            w_cnt_nxt     = c_ZERO;
            w_tip_nxt     = 1'b0;
            w_en_nxt      = 1'b0;
            w_aborted_nxt = 1'b1;
            w_irq_nxt     = w_irq_hold;
        end

        w_ss_nxt = ass ? ~(ss & {SS_NB{w_tip_nxt}}) : ~ss;
    end

    // State and output registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= c_ZERO;
            r_tip       <= 1'b0;
            r_clkgen_go <= 1'b0;
            r_clkgen_en <= 1'b0;
            r_aborted   <= 1'b0;
            r_irq       <= 1'b0;
            r_ss_pad    <= {SS_NB{1'b1}};
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_cnt_nxt;
            r_tip       <= w_tip_nxt;
            r_clkgen_go <= w_go_nxt;
            r_clkgen_en <= w_en_nxt;
            r_aborted   <= w_aborted_nxt;
            r_irq       <= w_irq_nxt;
            r_ss_pad    <= w_ss_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_xfer_ctrl
//  Description : Directed self-checking bench for spi_xfer_ctrl with a
//                simple 1:1 clock-generator edge model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_ctrl;

    localparam int LEN_W = 7;
    localparam int SS_NB = 8;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             go, abort, rx_negedge, tx_negedge, ass, ie, irq_clr;
    logic [LEN_W-1:0] char_len;
    logic [SS_NB-1:0] ss;
    logic             pos_edge = 1'b0;
    logic             neg_edge = 1'b0;
    logic             clkgen_go, clkgen_en, last_clk, tip, tx_shift, rx_sample;
    logic             done, aborted, irq;
    logic [LEN_W:0]   bit_cnt;
    logic [SS_NB-1:0] ss_pad_o;

    int total = 0;
    int bad   = 0;
    int n_rx = 0, n_tx = 0, n_done = 0, n_last = 0, n_last_bad = 0;
    logic ph = 1'b0;

    spi_xfer_ctrl #(.LEN_W(LEN_W), .SS_NB(SS_NB)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .go(go), .abort(abort),
        .char_len(char_len), .rx_negedge(rx_negedge), .tx_negedge(tx_negedge),
        .ass(ass), .ss(ss), .ie(ie), .irq_clr(irq_clr),
        .pos_edge(pos_edge), .neg_edge(neg_edge),
        .clkgen_go(clkgen_go), .clkgen_en(clkgen_en), .last_clk(last_clk),
        .tip(tip), .tx_shift(tx_shift), .rx_sample(rx_sample),
        .bit_cnt(bit_cnt), .done(done), .aborted(aborted), .irq(irq),
        .ss_pad_o(ss_pad_o)
    );

    always #5 clk_in = ~clk_in;

    // Clock-generator model: while enabled, alternate neg then pos pulses
    always @(posedge clk_in) begin
        #2;
        if (clkgen_en) begin
            neg_edge = ~ph;
            pos_edge = ph;
            ph       = ~ph;
        end else begin
            neg_edge = 1'b0;
            pos_edge = 1'b0;
            ph       = 1'b0;
        end
    end

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk_in) begin
        if (rx_sample) n_rx = n_rx + 1;
        if (tx_shift)  n_tx = n_tx + 1;
        if (done)      n_done = n_done + 1;
        if (last_clk)  n_last = n_last + 1;
        if (last_clk && bit_cnt != 8'd1) n_last_bad = n_last_bad + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    // go pulse; returns positioned in cycle 1 after the accepting edge
    task automatic start_xfer();
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    // advance until done is seen; cyc counts cycles since the accepting edge
    task automatic wait_done(input int bound, inout int cyc);
        while (done !== 1'b1 && cyc < bound) begin
            tick();
            cyc = cyc + 1;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int cyc;
        int rx0, tx0, dn0, lc0, lb0;
        rst_n = 1'b0; go = 1'b0; abort = 1'b0; char_len = 7'd8;
        tx_negedge = 1'b1; rx_negedge = 1'b0; ass = 1'b1; ss = 8'h05;
        ie = 1'b0; irq_clr = 1'b0;
        tick(); tick();
        chk("rst_tip", {31'd0, tip}, 32'd0);
        chk("rst_bit_cnt", {24'd0, bit_cnt}, 32'd0);
        chk("rst_clkgen_en", {31'd0, clkgen_en}, 32'd0);
        chk("rst_clkgen_go", {31'd0, clkgen_go}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_ss_pad", {24'd0, ss_pad_o}, 32'hFF);
        rst_n = 1'b1;
        tick();

        // 8-bit transfer, tx on neg, rx on pos
        chk("idle_ss_pad", {24'd0, ss_pad_o}, 32'hFF);
        rx0 = n_rx; tx0 = n_tx; dn0 = n_done; lc0 = n_last; lb0 = n_last_bad;
        start_xfer();
        chk("c1_clkgen_go", {31'd0, clkgen_go}, 32'd1);
        chk("c1_clkgen_en", {31'd0, clkgen_en}, 32'd0);
        chk("c1_tip", {31'd0, tip}, 32'd1);
        chk("c1_bit_cnt", {24'd0, bit_cnt}, 32'd8);
        chk("c1_ss_pad", {24'd0, ss_pad_o}, 32'hFA);
        tick();
        chk("c2_clkgen_go", {31'd0, clkgen_go}, 32'd0);
        chk("c2_clkgen_en", {31'd0, clkgen_en}, 32'd1);
        cyc = 2;
        wait_done(60, cyc);
        chk("x8_done_cycle", cyc, 32'd18);
        chk("x8_done_clkgen_en", {31'd0, clkgen_en}, 32'd0);
        tick();
        chk("x8_tip_after", {31'd0, tip}, 32'd0);
        chk("x8_ss_after", {24'd0, ss_pad_o}, 32'hFF);
        chk("x8_rx_count", n_rx - rx0, 32'd8);
        chk("x8_tx_count", n_tx - tx0, 32'd8);
        chk("x8_last_clk_cycles", n_last - lc0, 32'd2);
        chk("x8_last_clk_bad", n_last_bad - lb0, 32'd0);
        chk("x8_done_once", n_done - dn0, 32'd1);
        chk("x8_irq_ie0", {31'd0, irq}, 32'd0);

        // char_len = 0 selects 128 bits
        char_len = 7'd0;
        rx0 = n_rx; tx0 = n_tx; dn0 = n_done;
        start_xfer();
        chk("x128_bit_cnt", {24'd0, bit_cnt}, 32'd128);
        cyc = 1;
        wait_done(400, cyc);
        chk("x128_done_cycle", cyc, 32'd258);
        tick();
        chk("x128_rx_count", n_rx - rx0, 32'd128);
        chk("x128_tx_count", n_tx - tx0, 32'd128);
        chk("x128_done_once", n_done - dn0, 32'd1);

        // abort after the 3rd sample, with interrupts enabled
        char_len = 7'd8; ie = 1'b1;
        rx0 = n_rx; dn0 = n_done;
        start_xfer();
        cyc = 1;
        while ((n_rx - rx0) < 3 && cyc < 40) begin
            tick();
            cyc = cyc + 1;
        end
        chk("ab_third_sample_cycle", cyc, 32'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_aborted", {31'd0, aborted}, 32'd1);
        chk("ab_clkgen_en", {31'd0, clkgen_en}, 32'd0);
        chk("ab_bit_cnt", {24'd0, bit_cnt}, 32'd0);
        chk("ab_tip", {31'd0, tip}, 32'd0);
        tick();
        chk("ab_aborted_1cyc", {31'd0, aborted}, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("ab_no_done", n_done - dn0, 32'd0);
        chk("ab_rx_count", n_rx - rx0, 32'd3);
        chk("ab_irq", {31'd0, irq}, 32'd0);

        // go together with abort in IDLE is ignored
        go = 1'b1; abort = 1'b1;
        tick();
        go = 1'b0; abort = 1'b0;
        chk("goab_tip", {31'd0, tip}, 32'd0);
        chk("goab_aborted", {31'd0, aborted}, 32'd0);

        // back-to-back 4-bit transfers with irq set/clear collision
        char_len = 7'd4;
        start_xfer();
        cyc = 1;
        wait_done(40, cyc);
        chk("x4a_done_cycle", cyc, 32'd10);
        tick();
        chk("x4a_irq_set", {31'd0, irq}, 32'd1);
        start_xfer();
        cyc = 1;
        wait_done(40, cyc);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("x4b_irq_set_wins", {31'd0, irq}, 32'd1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("irq_cleared", {31'd0, irq}, 32'd0);

        // manual slave-select mode
        ass = 1'b0;
        tick();
        chk("ass0_idle_ss", {24'd0, ss_pad_o}, 32'hFA);
        ass = 1'b1;
        tick();
        chk("ass1_idle_ss", {24'd0, ss_pad_o}, 32'hFF);

        // extra go during RUN is ignored
        char_len = 7'd8;
        rx0 = n_rx; dn0 = n_done;
        start_xfer();
        cyc = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            cyc = cyc + 1;
        end
        go = 1'b1;
        tick();
        cyc = cyc + 1;
        go = 1'b0;
        wait_done(60, cyc);
        chk("gorun_done_cycle", cyc, 32'd18);
        tick();
        chk("gorun_rx_count", n_rx - rx0, 32'd8);
        chk("gorun_irq", {31'd0, irq}, 32'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("gorun_no_requeue", {31'd0, tip}, 32'd0);

        // asynchronous reset mid-transfer
        start_xfer();
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_tip", {31'd0, tip}, 32'd0);
        chk("arst_clkgen_en", {31'd0, clkgen_en}, 32'd0);
        chk("arst_bit_cnt", {24'd0, bit_cnt}, 32'd0);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        chk("arst_ss_pad", {24'd0, ss_pad_o}, 32'hFF);
        chk("arst_aborted", {31'd0, aborted}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("arst_idle_tip", {31'd0, tip}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
